// File: rtl/tqvp_cattuto_ws2812b_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tqvp_cattuto_ws2812b_receiver
//
// Decodes a WS2812B single-wire NRZ stream, as an LED sees it, into 24-bit
// GRB words. Each high pulse is measured in clock cycles. A pulse of at least
// T1_MIN cycles is a 1, and a shorter valid pulse is a 0. A low gap of
// RESET_CYCLES cycles is the reset/latch condition. Default timing is for a
// 64 MHz clock.
//
// Optional feature: define WS2812B_FORWARD_EN to enable daisy-chain
// forwarding on dout. The first word after a latch or resync is consumed.
// Every later pulse is copied to dout with a 2-clk delay. Without the macro,
// dout is tied to 0.
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   din        asynchronous WS2812B data line
//   rx_data    last completed word {G,R,B}; first received bit is rx_data[23]
//   rx_valid   rx_data holds an unconsumed word
//   rx_ready   consumer accepts rx_data while rx_valid=1
//   rx_latch   1-cycle pulse: latch gap seen after at least one bit
//   rx_error   1-cycle pulse: glitch, stuck-high line, or partial word at latch
//   rx_overrun 1-cycle pulse: completed word dropped while the output was full
//   dout       forwarded stream (0 unless WS2812B_FORWARD_EN)
//   dbg_state  current decoder state (0 SYNC, 1 IDLE, 2 HIGH, 3 LOW)
//
// Handshake: a word transfers on every clock edge where rx_valid=1 and
// rx_ready=1. While rx_valid=1 and no transfer has happened, rx_data holds
// its value. rx_valid may rise at any time and does not depend on rx_ready.
// ---------------------------------------------------------------------------
module tqvp_cattuto_ws2812b_receiver #(
  parameter int GLITCH_MIN   = 8,
  parameter int T1_MIN       = 38,
  parameter int HIGH_MAX     = 128,
  parameter int RESET_CYCLES = 3200,
  parameter int CNT_W        = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_latch,
  output logic        rx_error,
  output logic        rx_overrun,
  output logic        dout,
  output logic [1:0]  dbg_state
);

  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_MIN);
  localparam logic [CNT_W-1:0] T1_C     = CNT_W'(T1_MIN);
  localparam logic [CNT_W-1:0] HIGH_C   = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_cnt;
  logic [23:0]      shreg;
  logic             word_done;  // shreg holds a complete word this cycle
  logic             din_m;
  logic             din_s;

`ifdef WS2812B_FORWARD_EN
  logic fwd;    // forwarding active
  logic armed;  // next completed word is our own, not forwarded
`endif

  assign dbg_state = state;

  // Two-flop synchronizer for the asynchronous line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SYNC;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_done  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_latch   <= 1'b0;
      rx_error   <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef WS2812B_FORWARD_EN
      fwd        <= 1'b0;
      armed      <= 1'b0;
`endif
    end else begin
      rx_latch   <= 1'b0;
      rx_error   <= 1'b0;
      rx_overrun <= 1'b0;
      word_done  <= 1'b0;

      case (state)
        // Wait for a full reset gap before trusting the line. Any high
        // restarts the gap count.
        SYNC: begin
          if (din_s) begin
            cnt <= '0;
          end else if (cnt == RESET_C) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef WS2812B_FORWARD_EN
            armed <= 1'b1;
`endif
          end else begin
            cnt <= cnt + ONE_C;
          end
        end

        IDLE: begin
          if (din_s) begin
            state <= HIGH;
            cnt   <= ONE_C;
          end
        end

        // cnt equals the width of the high pulse so far.
        HIGH: begin
          if (cnt == HIGH_C || (!din_s && cnt < GLITCH_C)) begin
            rx_error <= 1'b1;
            bit_cnt  <= '0;
            shreg    <= '0;
            cnt      <= '0;
            state    <= SYNC;
`ifdef WS2812B_FORWARD_EN
            fwd      <= 1'b0;
`endif
          end else if (din_s) begin
            cnt <= cnt + ONE_C;
          end else begin
            shreg <= {shreg[22:0], (cnt >= T1_C)};
            state <= LOW;
            cnt   <= ONE_C;
            if (bit_cnt == 5'd23) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
`ifdef WS2812B_FORWARD_EN
              if (armed) begin
                fwd   <= 1'b1;
                armed <= 1'b0;
              end
`endif
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        LOW: begin
          if (din_s) begin
            state <= HIGH;
            cnt   <= ONE_C;
          end else if (cnt == RESET_C) begin
            rx_latch <= 1'b1;
            // A latch that arrives mid-word discards the partial word.
            rx_error <= (bit_cnt != 5'd0);
            bit_cnt  <= '0;
            shreg    <= '0;
            cnt      <= '0;
            state    <= IDLE;
`ifdef WS2812B_FORWARD_EN
            fwd      <= 1'b0;
            armed    <= 1'b1;
`endif
          end else begin
            cnt <= cnt + ONE_C;
          end
        end

        default: begin
          state <= SYNC;
          cnt   <= '0;
        end
      endcase

      // Output register and handshake. shreg is still stable one cycle
      // after completion because the next bit takes at least GLITCH_MIN
      // cycles to arrive.
      if (word_done) begin
        if (rx_valid && !rx_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef WS2812B_FORWARD_EN
  assign dout = din_s & fwd;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_tqvp_cattuto_ws2812b_receiver.sv
`timescale 1ns/1ps
// Bench for tqvp_cattuto_ws2812b_receiver: directed WS2812B waveforms.
// Expected words are queued when they are sent. A monitor checks each
// accepted word and counts the pulse outputs. The main sequence checks those
// counts after each phase.
module tb_tqvp_cattuto_ws2812b_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_latch;
  logic        rx_error;
  logic        rx_overrun;
  logic        dout;
  logic [1:0]  dbg_state;

  tqvp_cattuto_ws2812b_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_latch   (rx_latch),
    .rx_error   (rx_error),
    .rx_overrun (rx_overrun),
    .dout       (dout),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int err_cnt = 0, latch_cnt = 0, ovr_cnt = 0, coinc_cnt = 0, acc_cnt = 0;
  int dout_bad = 0, dout_rise = 0;
  int e0, l0, o0, c0, a0, r0;
  logic        win = 1'b0;      // dout should mirror din delayed 2 clk
  logic        din_h1 = 1'b0, din_h2 = 1'b0;
  logic        dout_prev = 1'b0;
  logic        hold_prev = 1'b0;
  logic [23:0] data_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // din history sampled on the DUT edge
  always @(posedge clk) begin
    din_h1 <= din;
    din_h2 <= din_h1;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_error) err_cnt++;
      if (rx_latch) latch_cnt++;
      if (rx_overrun) ovr_cnt++;
      if (rx_latch && rx_error) coinc_cnt++;
      if (hold_prev && rx_valid) check("data_hold", {8'h0, rx_data}, {8'h0, data_prev});
      if (rx_valid && rx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%06h, expected none", rx_data);
        end else begin
          check("word", {8'h0, rx_data}, {8'h0, exp_q.pop_front()});
        end
      end
      hold_prev = rx_valid && !rx_ready;
      data_prev = rx_data;
      if (dout !== (win ? din_h2 : 1'b0)) dout_bad++;
      if (dout && !dout_prev) dout_rise++;
      dout_prev = dout;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic d, input int n);
    din = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    tick(1'b1, b ? 51 : 26);
    tick(1'b0, b ? 29 : 54);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [23:0] w, input bit expect_it);
    if (expect_it) exp_q.push_back(w);
    send_bits(w, 24);
  endtask

  task automatic snap();
    e0 = err_cnt; l0 = latch_cnt; o0 = ovr_cnt; c0 = coinc_cnt; a0 = acc_cnt; r0 = dout_rise;
  endtask

  task automatic set_win(input logic v);
`ifdef WS2812B_FORWARD_EN
    win = v;
`else
    win = 1'b0;
    if (v) win = 1'b0;
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    din = 1'b0;
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_data", {8'h0, rx_data}, 32'h0);
    check("rst_latch", {31'h0, rx_latch}, 32'h0);
    check("rst_error", {31'h0, rx_error}, 32'h0);
    check("rst_overrun", {31'h0, rx_overrun}, 32'h0);
    check("rst_dout", {31'h0, dout}, 32'h0);
    rst_n = 1'b1;

    // Basic word, then one latch and quiet idle.
    tick(1'b0, 3300);
    snap();
    send_word(24'hFF00A5, 1'b1);
    tick(1'b0, 3300);
    check("p1_words", acc_cnt - a0, 1);
    check("p1_errors", err_cnt - e0, 0);
    check("p1_latch", latch_cnt - l0, 1);
    tick(1'b0, 1000);
    check("p1_idle_latch", latch_cnt - l0, 1);

    // Glitch after 10 bits, resync, clean word.
    snap();
    send_bits(24'h0002CE, 10);
    tick(1'b1, 4);
    tick(1'b0, 76);
    tick(1'b0, 3300);
    check("p2_glitch_err", err_cnt - e0, 1);
    check("p2_no_latch", latch_cnt - l0, 0);
    send_word(24'h123456, 1'b1);
    tick(1'b0, 3300);
    check("p2_words", acc_cnt - a0, 1);
    check("p2_errors", err_cnt - e0, 1);
    check("p2_latch", latch_cnt - l0, 1);

    // Overrun with consumer stalled.
    snap();
    rx_ready = 1'b0;
    send_word(24'h0000FF, 1'b1);
    set_win(1'b1);
    send_word(24'hFFFFFF, 1'b0);
    tick(1'b0, 20);
    check("p3_overrun", ovr_cnt - o0, 1);
    check("p3_valid", {31'h0, rx_valid}, 32'h1);
    check("p3_data", {8'h0, rx_data}, 32'h0000FF);
    rx_ready = 1'b1;
    tick(1'b0, 1);
    rx_ready = 1'b0;
    check("p3_valid_clr", {31'h0, rx_valid}, 32'h0);
    tick(1'b0, 3300);
    set_win(1'b0);
    rx_ready = 1'b1;
    check("p3_words", acc_cnt - a0, 1);
    check("p3_latch", latch_cnt - l0, 1);
    check("p3_errors", err_cnt - e0, 0);
`ifdef WS2812B_FORWARD_EN
    check("p3_fwd_pulses", dout_rise - r0, 24);
`endif

    // Partial word at latch.
    snap();
    send_bits(24'h000A5C, 12);
    tick(1'b0, 3300);
    check("p4_latch", latch_cnt - l0, 1);
    check("p4_error", err_cnt - e0, 1);
    check("p4_same_cycle", coinc_cnt - c0, 1);
    check("p4_valid", {31'h0, rx_valid}, 32'h0);
    check("p4_words", acc_cnt - a0, 0);

    // Stuck high, then a word inside the resync gap is ignored.
    snap();
    tick(1'b1, 200);
    tick(1'b0, 1000);
    send_word(24'hABCDEF, 1'b0);
    tick(1'b0, 3300);
    check("p5_stuck_err", err_cnt - e0, 1);
    check("p5_no_latch", latch_cnt - l0, 0);
    check("p5_ignored", acc_cnt - a0, 0);
    send_word(24'h5A5A5A, 1'b1);
    tick(1'b0, 3300);
    check("p5_recover", acc_cnt - a0, 1);
    check("p5_latch", latch_cnt - l0, 1);

    // Two back-to-back words; the second is the forwarded one.
    snap();
    send_word(24'hAAAAAA, 1'b1);
    set_win(1'b1);
    send_word(24'h55AA55, 1'b1);
    tick(1'b0, 3300);
    set_win(1'b0);
    check("p6_words", acc_cnt - a0, 2);
    check("p6_latch", latch_cnt - l0, 1);
`ifdef WS2812B_FORWARD_EN
    check("p6_fwd_pulses", dout_rise - r0, 24);
`else
    check("p6_fwd_pulses", dout_rise - r0, 0);
`endif
    snap();
    send_word(24'h0F0F0F, 1'b1);
    tick(1'b0, 3300);
    check("p6_after_latch_dout", dout_rise - r0, 0);
    check("p6_last_word", acc_cnt - a0, 1);

    check("dout_trace", dout_bad, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
